// File: rtl/fpadd_rr_sched.sv
// Round-robin scheduler feeding one shared fixed-latency FP adder.
// Operand pairs from NREQ requesters are granted one per cycle, registered
// onto the adder inputs, and a requester tag rides alongside the adder's
// pipeline so each result comes back labelled with its owner.

// Per-requester operand gating: a granted lane drives its (sign-adjusted)
// operands, every other lane drives zero, so the top can OR-reduce.
module fpadd_rr_lane (
    input  logic        gnt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] a_m,
    output logic [31:0] b_m
);
    // Subtraction is a sign flip of b; masking keeps the OR-mux one-hot safe.
    always_comb begin
        a_m = gnt ? a : 32'h0;
        b_m = gnt ? {b[31] ^ sub, b[30:0]} : 32'h0;
    end
endmodule

module fpadd_rr_sched #(
    parameter  int NREQ    = 4,
    parameter  int IDW     = 2,
    parameter  int LATENCY = 5,
    localparam int CNTW    = $clog2(LATENCY + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    input  logic                 hold,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic [CNTW-1:0]      inflight,
    output logic                 idle
);

    // Tag pipe: stage k holds the op accepted k edges ago (stage 0 = newest).
    logic [LATENCY:0]               vld_pipe_q, vld_pipe_d;
    logic [LATENCY:0][IDW-1:0]      id_pipe_q, id_pipe_d;

    logic [IDW-1:0]                 ptr_q, ptr_d;
    logic [31:0]                    add_a_q, add_a_d;
    logic [31:0]                    add_b_q, add_b_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]                 rsp_id_q, rsp_id_d;
    logic [31:0]                    rsp_data_q, rsp_data_d;
    logic [CNTW-1:0]                inflight_q, inflight_d;

    logic [NREQ-1:0]                gnt;
    logic [IDW-1:0]                 gnt_idx;
    logic                           gnt_any;
    logic [IDW-1:0]                 cand;
    logic [NREQ-1:0][31:0]          a_m, b_m;
    logic [31:0]                    a_sel, b_sel;

    // Round-robin search starting just after the last granted requester;
    // hold suppresses every grant in the same cycle.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        if (!hold) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDW'((int'(ptr_q) + k) % NREQ);
                if (req_valid[cand] && !gnt_any) begin
                    gnt_any      = 1'b1;
                    gnt[cand]    = 1'b1;
                    gnt_idx      = cand;
                end
            end
        end
    end

    assign req_ready = gnt;

    // One gating lane per requester; the grant is one-hot so OR is a mux.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        fpadd_rr_lane u_lane (
            .gnt (gnt[i]),
            .a   (req_a[32*i +: 32]),
            .b   (req_b[32*i +: 32]),
            .sub (req_sub[i]),
            .a_m (a_m[i]),
            .b_m (b_m[i])
        );
    end

    // OR-reduce the masked lane operands into the selected pair.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_sel = a_sel | a_m[i];
            b_sel = b_sel | b_m[i];
        end
    end

    // Next state: operand capture, tag shift, response capture, occupancy.
    always_comb begin
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        ptr_d   = ptr_q;
        if (gnt_any) begin
            add_a_d = a_sel;
            add_b_d = b_sel;
            ptr_d   = gnt_idx;
        end

        vld_pipe_d   = {vld_pipe_q[LATENCY-1:0], gnt_any};
        id_pipe_d[0] = gnt_idx;
        for (int k = 1; k <= LATENCY; k++) begin
            id_pipe_d[k] = id_pipe_q[k-1];
        end

        // The oldest tag lines up with add_out for that op.
        rsp_valid_d = vld_pipe_q[LATENCY];
        rsp_id_d    = id_pipe_q[LATENCY];
        rsp_data_d  = vld_pipe_q[LATENCY] ? add_out : rsp_data_q;

        // Count down on the edge that raises rsp_valid so the peak stays at
        // LATENCY+1 under back-to-back traffic.
        inflight_d = inflight_q + CNTW'(gnt_any) - CNTW'(vld_pipe_q[LATENCY]);
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            id_pipe_q   <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            id_pipe_q   <= id_pipe_d;
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            inflight_q  <= inflight_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign inflight  = inflight_q;
    assign idle      = hold && (inflight_q == '0);

endmodule

// File: tb/tb_fpadd_rr_sched.sv
// Directed bench for fpadd_rr_sched with a 5-stage stand-in adder.
module tb_fpadd_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_sub;
    logic                hold;
    logic [31:0]         add_a, add_b, add_out;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_data;
    logic [2:0]          inflight;
    logic                idle;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fpadd_rr_sched #(.NREQ(NREQ), .IDW(IDW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .hold      (hold),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .inflight  (inflight),
        .idle      (idle)
    );

    // Stand-in adder: exact sums for the operand pairs used here.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
            {32'h40400000, 32'hBF800000}: return 32'h40000000; // 3-1
            {32'h3F800000, 32'h00000000}: return 32'h3F800000; // 1+0
            {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1
            {32'h3F800000, 32'h40400000}: return 32'h40800000; // 1+3
            default:                      return a + b;
        endcase
    endfunction

    logic [31:0] fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= fp_model(add_a, add_b);
        for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign add_out = fpipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i]        = s;
    endtask

    logic [31:0] sums [NREQ];
    logic [3:0]  exp_rdy;
    logic [IDW-1:0] exp_id;
    int peak;
    int exp_inf;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single op from requester 2: 1.0 + 2.0
        set_op(2, 32'h3F800000, 32'h40000000, 1'b0);
        req_valid = 4'b0100;
        #1 chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("single_add_a", add_a, 32'h3F800000);
        chk("single_add_b", add_b, 32'h40000000);
        chk("single_inflight1", 32'(inflight), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("single_no_early_rsp", 32'(rsp_valid), 32'h0);
        end
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h2);
        chk("single_rsp_data", rsp_data, 32'h40400000);
        chk("single_inflight0", 32'(inflight), 32'h0);
        tick();
        chk("single_pulse", 32'(rsp_valid), 32'h0);
        chk("single_data_hold", rsp_data, 32'h40400000);

        // Subtract from requester 0: 3.0 - 1.0
        set_op(0, 32'h40400000, 32'h3F800000, 1'b1);
        req_valid = 4'b0001;
        #1 chk("sub_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("sub_add_a", add_a, 32'h40400000);
        chk("sub_add_b", add_b, 32'hBF800000);
        repeat (5) tick();
        tick();
        chk("sub_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("sub_rsp_id", 32'(rsp_id), 32'h0);
        chk("sub_rsp_data", rsp_data, 32'h40000000);

        // Operands for the remaining tests: requester i computes 1.0 + i
        set_op(0, 32'h3F800000, 32'h00000000, 1'b0);
        set_op(1, 32'h3F800000, 32'h3F800000, 1'b0);
        set_op(2, 32'h3F800000, 32'h40000000, 1'b0);
        set_op(3, 32'h3F800000, 32'h40400000, 1'b0);
        sums[0] = 32'h3F800000; sums[1] = 32'h40000000;
        sums[2] = 32'h40400000; sums[3] = 32'h40800000;

        // Requester 3 alone moves the pointer to 3
        req_valid = 4'b1000;
        #1 chk("r3_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        repeat (5) tick();
        tick();
        chk("r3_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("r3_rsp_id", 32'(rsp_id), 32'h3);
        chk("r3_rsp_data", rsp_data, 32'h40800000);
        tick();

        // Fairness: all valid for 8 cycles
        peak = 0;
        for (int c = 0; c < 14; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                exp_rdy = 4'b0001 << (c % 4);
                chk("rr_ready", 32'(req_ready), 32'(exp_rdy));
            end
            tick();
            if (c >= 6) begin
                exp_id = IDW'((c - 6) % 4);
                chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
                chk("rr_rsp_id", 32'(rsp_id), 32'(exp_id));
                chk("rr_rsp_data", rsp_data, sums[exp_id]);
            end else begin
                chk("rr_rsp_idle", 32'(rsp_valid), 32'h0);
            end
            exp_inf = (c < 8) ? ((c + 1 < 6) ? c + 1 : 6) : 13 - c;
            chk("rr_inflight", 32'(inflight), 32'(exp_inf));
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        chk("rr_peak", 32'(peak), 32'd6);

        // Wrap/skip: ptr=3, requesters 1 and 3 valid
        req_valid = 4'b1010;
        #1 chk("wrap_g1", 32'(req_ready), 32'h2);
        tick();
        chk("wrap_g3", 32'(req_ready), 32'h8);
        tick();
        chk("wrap_g1b", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_id = (k == 1) ? 2'd3 : 2'd1;
            chk("wrap_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("wrap_rsp_id", 32'(rsp_id), 32'(exp_id));
            chk("wrap_rsp_data", rsp_data, sums[exp_id]);
        end
        tick();

        // Drain: 3 ops in flight (grants 2,3,0), then hold with all valid
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            exp_rdy = 4'b0100 << k | ((k == 2) ? 4'b0001 : 4'b0000);
            if (k == 2) exp_rdy = 4'b0001;
            chk("drain_pre_ready", 32'(req_ready), 32'(exp_rdy));
            tick();
        end
        hold = 1'b1;
        #1;
        chk("drain_ready_now", 32'(req_ready), 32'h0);
        chk("drain_idle_busy", 32'(idle), 32'h0);
        for (int k = 3; k <= 9; k++) begin
            tick();
            chk("drain_ready", 32'(req_ready), 32'h0);
            if (k >= 6 && k <= 8) begin
                exp_id = (k == 6) ? 2'd2 : (k == 7) ? 2'd3 : 2'd0;
                chk("drain_rsp_valid", 32'(rsp_valid), 32'h1);
                chk("drain_rsp_id", 32'(rsp_id), 32'(exp_id));
                chk("drain_rsp_data", rsp_data, sums[exp_id]);
            end else begin
                chk("drain_rsp_quiet", 32'(rsp_valid), 32'h0);
            end
            if (k == 7) chk("drain_idle_before_last", 32'(idle), 32'h0);
            if (k == 9) chk("drain_idle_after", 32'(idle), 32'h1);
        end
        hold = 1'b0;
        req_valid = '0;
        tick();

        // Reset mid-operation with 4 ops in flight
        req_valid = 4'b1111;
        repeat (4) tick();
        req_valid = '0;
        chk("mid_inflight4", 32'(inflight), 32'h4);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_inflight", 32'(inflight), 32'h0);
        chk("mid_add_a", add_a, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
        end
        req_valid = 4'b1111;
        #1 chk("mid_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("mid_inflight_after", 32'(inflight), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
